// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_queue_pkg
// Brief   : Shared constants, entry type and helpers for the instruction
//           prefetch queue.
// Revision: 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

    localparam int          c_INST_ADDR_W    = 32;
    localparam int          c_INST_W         = 32;
    localparam int          c_IFQ_DEPTH_LOG2 = 2;
    localparam logic        c_CHIP_ENABLE    = 1'b1;
    localparam logic        c_CHIP_DISABLE   = 1'b0;
    localparam logic [31:0] c_ZERO_WORD      = 32'h0000_0000;

    typedef struct packed {
        logic [c_INST_ADDR_W-1:0] pc;
        logic [c_INST_W-1:0]      inst;
    } ifq_entry_t;

    function automatic logic [c_INST_ADDR_W-1:0] word_align(input logic [c_INST_ADDR_W-1:0] addr);
        return {addr[c_INST_ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ifq_fifo
// Brief   : Generic synchronous FIFO with flush; head reads as zero when empty.
// Revision: 1.0 - initial release
// ============================================================================
module ifq_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Caller guarantees no push when full unless a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_queue
// Brief   : Instruction prefetch queue: owns the fetch PC, drives the ROM and
//           buffers {pc,inst} pairs; optional flush-discard counter enabled
//           by defining IFQ_FLUSH_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = (1 << c_IFQ_DEPTH_LOG2),
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce_o,
    output logic [c_INST_ADDR_W-1:0] rom_addr_o,
    input  logic [c_INST_W-1:0]      rom_data_i,
    input  logic                     flush_i,
    input  logic [c_INST_ADDR_W-1:0] new_pc_i,
    input  logic                     id_ready_i,
    output logic                     valid_o,
    output logic [c_INST_ADDR_W-1:0] pc_o,
    output logic [c_INST_W-1:0]      inst_o
`ifdef IFQ_FLUSH_CNT_EN
    ,
    output logic [31:0]              flush_cnt_o
`endif
);

    localparam int            CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic                     r_run;
    logic [c_INST_ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]            w_count;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_push;
    ifq_entry_t               w_wr_entry;
    ifq_entry_t               w_head;

    assign w_valid    = (w_count != '0);
    assign w_pop      = w_valid & id_ready_i & ~flush_i;
    // Gating with rst keeps the ROM idle while reset is held, even before r_run settles.
    assign w_push     = ~rst & r_run & ~flush_i & ((w_count < c_FULL) | w_pop);
    assign w_wr_entry = '{pc: r_fetch_pc, inst: rom_data_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_run <= 1'b1;
            if (flush_i) begin
                r_fetch_pc <= word_align(new_pc_i);
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    ifq_fifo #(
        .WIDTH (c_INST_ADDR_W + c_INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .i_wdata (w_wr_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign rom_ce_o   = w_push ? c_CHIP_ENABLE : c_CHIP_DISABLE;
    assign rom_addr_o = r_fetch_pc;
    assign valid_o    = w_valid;
    assign pc_o       = w_head.pc;
    assign inst_o     = w_head.inst;

`ifdef IFQ_FLUSH_CNT_EN
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= c_ZERO_WORD;
        end else if (flush_i) begin
            r_flush_cnt <= sat_add32(r_flush_cnt, 32'(w_count));
        end
    end

    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_queue
// Brief   : Directed self-checking bench for inst_fetch_queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        id_ready_i;

    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] flush_cnt_o;

    logic        w2_rom_ce;
    logic [31:0] w2_rom_addr;
    logic [31:0] w2_rom_data;
    logic        w2_valid;
    logic [31:0] w2_pc;
    logic [31:0] w2_inst;
    logic [31:0] w2_flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_fcnt = 0;

    always #5 clk = ~clk;

    // ROM word k (byte address 4k) holds 32'h1000_0000 + k.
    assign rom_data_i  = 32'h1000_0000 + (rom_addr_o >> 2);
    assign w2_rom_data = 32'h1000_0000 + (w2_rom_addr >> 2);

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_o   (rom_ce_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .flush_i    (flush_i),
        .new_pc_i   (new_pc_i),
        .id_ready_i (id_ready_i),
        .valid_o    (valid_o),
        .pc_o       (pc_o),
        .inst_o     (inst_o)
`ifdef IFQ_FLUSH_CNT_EN
        ,
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_o   (w2_rom_ce),
        .rom_addr_o (w2_rom_addr),
        .rom_data_i (w2_rom_data),
        .flush_i    (1'b0),
        .new_pc_i   (32'h0),
        .id_ready_i (1'b1),
        .valid_o    (w2_valid),
        .pc_o       (w2_pc),
        .inst_o     (w2_inst)
`ifdef IFQ_FLUSH_CNT_EN
        ,
        .flush_cnt_o(w2_flush_cnt)
`endif
    );

`ifndef IFQ_FLUSH_CNT_EN
    assign flush_cnt_o  = 32'h0;
    assign w2_flush_cnt = 32'h0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at "cycle 0": first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        id_ready_i = 1'b1;
        flush_i    = 1'b0;
        new_pc_i   = 32'h0;
        rst        = 1'b1;
        step();
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %08h exp 00000000", pc_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %08h exp 00000000", inst_o); end
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce got %0h exp 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %08h exp 00000000", rom_addr_o); end
`ifdef IFQ_FLUSH_CNT_EN
        checks++; if (flush_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", flush_cnt_o); end
`endif
    endtask

    task automatic test_stream();
        id_ready_i = 1'b1;
        do_reset();
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL stream_ce_c0 got %0h exp 0", rom_ce_o); end
        step();
        checks++; if (rom_ce_o !== 1'b1) begin errors++; $display("FAIL stream_ce_c1 got %0h exp 1", rom_ce_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_valid_c1 got %0h exp 0", valid_o); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %0h exp 1", k, valid_o); end
            checks++; if (pc_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc k=%0d got %08h exp %08h", k, pc_o, 32'(4 * k)); end
            checks++; if (inst_o !== 32'h1000_0000 + 32'(k)) begin errors++; $display("FAIL stream_inst k=%0d got %08h exp %08h", k, inst_o, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_stall();
        id_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL stall_ce_full got %0h exp 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h10) begin errors++; $display("FAIL stall_addr got %08h exp 00000010", rom_addr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL stall_head got %08h exp 00000000", pc_o); end
        step();
        checks++; if (rom_addr_o !== 32'h10) begin errors++; $display("FAIL stall_frozen_addr got %08h exp 00000010", rom_addr_o); end
        id_ready_i = 1'b1;
        #1;
        checks++; if (rom_ce_o !== 1'b1) begin errors++; $display("FAIL stall_ce_pop_full got %0h exp 1", rom_ce_o); end
        step();
        checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL stall_after_pop_pc got %08h exp 00000004", pc_o); end
        checks++; if (rom_addr_o !== 32'h14) begin errors++; $display("FAIL stall_after_pop_addr got %08h exp 00000014", rom_addr_o); end
    endtask

    // Continues from test_stall: queue holds 4,8,C,10 with id_ready_i=1.
    task automatic test_flush();
        step();
        id_ready_i = 1'b0;
        checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL flush_pre_head got %08h exp 00000008", pc_o); end
        flush_i  = 1'b1;
        new_pc_i = 32'h40;
        #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL flush_ce_in_flush got %0h exp 0", rom_ce_o); end
        step();
        flush_i = 1'b0;
        exp_fcnt = 4;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", valid_o); end
        checks++; if (rom_addr_o !== 32'h40) begin errors++; $display("FAIL flush_addr got %08h exp 00000040", rom_addr_o); end
`ifdef IFQ_FLUSH_CNT_EN
        checks++; if (flush_cnt_o !== 32'(exp_fcnt)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt_o, exp_fcnt); end
`endif
        step();
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL flush_target_pc got %08h exp 00000040", pc_o); end
        checks++; if (inst_o !== 32'h1000_0010) begin errors++; $display("FAIL flush_target_inst got %08h exp 10000010", inst_o); end
    endtask

    // Continues from test_flush: one entry (pc 0x40) queued, id_ready_i=0.
    task automatic test_flush_misaligned();
        id_ready_i = 1'b1;
        flush_i    = 1'b1;
        new_pc_i   = 32'h43;
        step();
        flush_i = 1'b0;
        exp_fcnt = exp_fcnt + 1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL misal_empty got %0h exp 0", valid_o); end
        checks++; if (rom_addr_o !== 32'h40) begin errors++; $display("FAIL misal_addr got %08h exp 00000040", rom_addr_o); end
`ifdef IFQ_FLUSH_CNT_EN
        checks++; if (flush_cnt_o !== 32'(exp_fcnt)) begin errors++; $display("FAIL misal_fcnt got %0d exp %0d", flush_cnt_o, exp_fcnt); end
`endif
        step();
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL misal_pc got %08h exp 00000040", pc_o); end
        // Held flush: the last target wins and the queue stays empty.
        flush_i  = 1'b1;
        new_pc_i = 32'h80;
        step();
        exp_fcnt = exp_fcnt + 1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL held1_valid got %0h exp 0", valid_o); end
        new_pc_i = 32'h10A;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL held2_valid got %0h exp 0", valid_o); end
        checks++; if (rom_addr_o !== 32'h108) begin errors++; $display("FAIL held2_addr got %08h exp 00000108", rom_addr_o); end
`ifdef IFQ_FLUSH_CNT_EN
        checks++; if (flush_cnt_o !== 32'(exp_fcnt)) begin errors++; $display("FAIL held_fcnt got %0d exp %0d", flush_cnt_o, exp_fcnt); end
`endif
        flush_i = 1'b0;
        step();
        checks++; if (pc_o !== 32'h108) begin errors++; $display("FAIL held_pc got %08h exp 00000108", pc_o); end
        checks++; if (inst_o !== 32'h1000_0042) begin errors++; $display("FAIL held_inst got %08h exp 10000042", inst_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0004;
        do_reset();
        step();
        checks++; if (w2_rom_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_first_addr got %08h exp fffffff8", w2_rom_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (w2_pc !== exp_pc[k]) begin errors++; $display("FAIL wrap_pc k=%0d got %08h exp %08h", k, w2_pc, exp_pc[k]); end
        end
        checks++; if (w2_inst !== 32'h1000_0001) begin errors++; $display("FAIL wrap_inst got %08h exp 10000001", w2_inst); end
    endtask

    task automatic test_reset_mid();
        id_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++; if (pc_o !== 32'h0 || valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got valid=%0h pc=%08h exp valid=1 pc=00000000", valid_o, pc_o); end
        rst      = 1'b1;
        flush_i  = 1'b1;
        new_pc_i = 32'h80;
        #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL rmid_ce_in_rst got %0h exp 0", rom_ce_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0h exp 0", valid_o); end
        checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("FAIL rmid_head got pc=%08h inst=%08h exp 0/0", pc_o, inst_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_addr got %08h exp 00000000", rom_addr_o); end
`ifdef IFQ_FLUSH_CNT_EN
        checks++; if (flush_cnt_o !== 32'h0) begin errors++; $display("FAIL rmid_fcnt got %0d exp 0", flush_cnt_o); end
`endif
        rst        = 1'b0;
        flush_i    = 1'b0;
        id_ready_i = 1'b1;
        step();
        step();
        checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h4) begin errors++; $display("FAIL rmid_restart got ce=%0h addr=%08h exp ce=1 addr=00000004", rom_ce_o, rom_addr_o); end
        checks++; if (pc_o !== 32'h0 || inst_o !== 32'h1000_0000) begin errors++; $display("FAIL rmid_first got pc=%08h inst=%08h exp 00000000/10000000", pc_o, inst_o); end
    endtask

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        new_pc_i   = 32'h0;
        id_ready_i = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_misaligned();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
